// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the single unified instruction/data memory of the multi-cycle core
// between two requesters: port 0 is the core access path, port 1 is the
// debug/loader port. The arbiter owns every memory control pin and returns
// a one-cycle done pulse to the port whose access completed.
//
// Build option: define ARB_FIXED_PRIO_EN to make the core win every tie
// (fixed priority). Without it, ties are resolved round-robin.
module mem_port_arbiter #(
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic          core_done,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_done,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          owner,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_write_data,
  output logic          mem_read,
  output logic          mem_write,
  input  logic [DW-1:0] mem_read_data
);

  // MEM_LAT is at most 15, so the remaining-cycles counter fits in 4 bits.
  localparam int            CW       = 4;
  localparam logic [CW-1:0] LAT_LOAD = CW'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t        state_r;
  logic [CW-1:0] lat_cnt_r;
  logic          last_grant_r;
  logic          owner_r;
  logic          we_r;
  logic [AW-1:0] addr_r;
  logic [DW-1:0] wdata_r;
  logic [DW-1:0] rdata_r;
  logic          busy_r;
  logic          core_done_r;
  logic          dbg_done_r;
  logic          mem_read_r;
  logic          mem_write_r;

  logic          grant_valid_s;
  logic          grant_port_s;
  logic          grant_we_s;
  logic [AW-1:0] grant_addr_s;
  logic [DW-1:0] grant_wdata_s;

  // Decide which port would be granted if the arbiter is idle this cycle
  always_comb begin
    grant_valid_s = core_req | dbg_req;
    grant_port_s  = 1'b0;
    if (core_req && dbg_req) begin
`ifdef ARB_FIXED_PRIO_EN
      grant_port_s = 1'b0;
`else
      grant_port_s = ~last_grant_r;
`endif
    end else if (dbg_req) begin
      grant_port_s = 1'b1;
    end else begin
      grant_port_s = 1'b0;
    end
  end

  // Select the payload of the winning port for latching at grant time
  always_comb begin
    grant_we_s    = 1'b0;
    grant_addr_s  = {AW{1'b0}};
    grant_wdata_s = {DW{1'b0}};
    if (grant_port_s) begin
      grant_we_s    = dbg_we;
      grant_addr_s  = dbg_addr;
      grant_wdata_s = dbg_wdata;
    end else begin
      grant_we_s    = core_we;
      grant_addr_s  = core_addr;
      grant_wdata_s = core_wdata;
    end
  end

  // Access sequencer: grant, drive memory for MEM_LAT cycles, respond once
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      lat_cnt_r    <= {CW{1'b0}};
      last_grant_r <= 1'b1;
      owner_r      <= 1'b0;
      we_r         <= 1'b0;
      addr_r       <= {AW{1'b0}};
      wdata_r      <= {DW{1'b0}};
      rdata_r      <= {DW{1'b0}};
      busy_r       <= 1'b0;
      core_done_r  <= 1'b0;
      dbg_done_r   <= 1'b0;
      mem_read_r   <= 1'b0;
      mem_write_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          core_done_r <= 1'b0;
          dbg_done_r  <= 1'b0;
          if (grant_valid_s) begin
            state_r      <= ST_ACCESS;
            lat_cnt_r    <= LAT_LOAD;
            last_grant_r <= grant_port_s;
            owner_r      <= grant_port_s;
            we_r         <= grant_we_s;
            addr_r       <= grant_addr_s;
            wdata_r      <= grant_wdata_s;
            busy_r       <= 1'b1;
            mem_read_r   <= ~grant_we_s;
            mem_write_r  <= grant_we_s;
          end else begin
            busy_r      <= 1'b0;
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
          end
        end
        ST_ACCESS: begin
          // The write strobe lasts only the first access cycle.
          mem_write_r <= 1'b0;
          if (lat_cnt_r == {CW{1'b0}}) begin
            if (!we_r) begin
              rdata_r <= mem_read_data;
            end else begin
              rdata_r <= rdata_r;
            end
            mem_read_r  <= 1'b0;
            core_done_r <= ~owner_r;
            dbg_done_r  <= owner_r;
            state_r     <= ST_RESP;
          end else begin
            lat_cnt_r <= lat_cnt_r - 4'd1;
          end
        end
        ST_RESP: begin
          core_done_r <= 1'b0;
          dbg_done_r  <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= ST_IDLE;
        end
        default: begin
          state_r     <= ST_IDLE;
          busy_r      <= 1'b0;
          core_done_r <= 1'b0;
          dbg_done_r  <= 1'b0;
          mem_read_r  <= 1'b0;
          mem_write_r <= 1'b0;
        end
      endcase
    end
  end

  assign core_done      = core_done_r;
  assign dbg_done       = dbg_done_r;
  assign rdata          = rdata_r;
  assign busy           = busy_r;
  assign owner          = owner_r;
  assign mem_address    = addr_r;
  assign mem_write_data = wdata_r;
  assign mem_read       = mem_read_r;
  // A reset arriving in the first access cycle must keep memory untouched.
  assign mem_write      = mem_write_r & ~rst;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: one instance with MEM_LAT=1
// (both ports used) and one with MEM_LAT=3 (debug port tied off).
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // MEM_LAT = 1 instance
  logic        c1_req, c1_we, c1_done, d1_req, d1_we, d1_done;
  logic [31:0] c1_addr, c1_wdata, d1_addr, d1_wdata;
  logic [31:0] rdata1, ma1, mwd1, mrd1;
  logic        busy1, owner1, mr1, mw1;

  // MEM_LAT = 3 instance
  logic        c3_req, c3_we, c3_done, d3_req, d3_we, d3_done;
  logic [31:0] c3_addr, c3_wdata, d3_addr, d3_wdata;
  logic [31:0] rdata3, ma3, mwd3, mrd3;
  logic        busy3, owner3, mr3, mw3;

  mem_port_arbiter #(.DW(32), .AW(32), .MEM_LAT(1)) dut1 (
    .clk(clk), .rst(rst),
    .core_req(c1_req), .core_we(c1_we), .core_addr(c1_addr), .core_wdata(c1_wdata), .core_done(c1_done),
    .dbg_req(d1_req), .dbg_we(d1_we), .dbg_addr(d1_addr), .dbg_wdata(d1_wdata), .dbg_done(d1_done),
    .rdata(rdata1), .busy(busy1), .owner(owner1),
    .mem_address(ma1), .mem_write_data(mwd1), .mem_read(mr1), .mem_write(mw1), .mem_read_data(mrd1)
  );

  mem_port_arbiter #(.DW(32), .AW(32), .MEM_LAT(3)) dut3 (
    .clk(clk), .rst(rst),
    .core_req(c3_req), .core_we(c3_we), .core_addr(c3_addr), .core_wdata(c3_wdata), .core_done(c3_done),
    .dbg_req(d3_req), .dbg_we(d3_we), .dbg_addr(d3_addr), .dbg_wdata(d3_wdata), .dbg_done(d3_done),
    .rdata(rdata3), .busy(busy3), .owner(owner3),
    .mem_address(ma3), .mem_write_data(mwd3), .mem_read(mr3), .mem_write(mw3), .mem_read_data(mrd3)
  );

  // Memories: combinational read, write on the rising edge, plus a bench preload path
  logic [31:0] mem1 [0:255];
  logic [31:0] mem3 [0:255];
  logic        pl1_en = 1'b0, pl3_en = 1'b0;
  logic [7:0]  pl_addr;
  logic [31:0] pl_data;

  always @(posedge clk) begin
    if (pl1_en) mem1[pl_addr] <= pl_data;
    else if (mw1) mem1[ma1[7:0]] <= mwd1;
  end
  always @(posedge clk) begin
    if (pl3_en) mem3[pl_addr] <= pl_data;
    else if (mw3) mem3[ma3[7:0]] <= mwd3;
  end
  assign mrd1 = mem1[ma1[7:0]];
  assign mrd3 = mem3[ma3[7:0]];

  // The tied-off debug port of the MEM_LAT=3 instance must never be served
  int d3_served = 0;
  always @(negedge clk) if (d3_done || owner3) d3_served <= d3_served + 1;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic preload(input bit which, input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_addr = a; pl_data = d;
    if (which) pl3_en = 1'b1; else pl1_en = 1'b1;
    @(negedge clk);
    pl1_en = 1'b0; pl3_en = 1'b0;
  endtask

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;
  vec_t vecs [6];

  // One complete transaction on dut1, checked for latency, strobes and result
  task automatic run_vec(input vec_t v, input int idx);
    int cyc = 0, nw = 0, nr = 0;
    bit seen = 1'b0, other = 1'b0;
    if (v.port) begin d1_req = 1'b1; d1_we = v.we; d1_addr = v.addr; d1_wdata = v.wdata; end
    else        begin c1_req = 1'b1; c1_we = v.we; c1_addr = v.addr; c1_wdata = v.wdata; end
    while (!seen && cyc < 20) begin
      @(negedge clk); cyc++;
      if (mw1) nw++;
      if (mr1) nr++;
      if (v.port ? c1_done : d1_done) other = 1'b1;
      if (v.port ? d1_done : c1_done) seen = 1'b1;
    end
    c1_req = 1'b0; d1_req = 1'b0;
    chk($sformatf("vec%0d_done", idx), seen, 1'b1);
    chk($sformatf("vec%0d_latency", idx), cyc, 2);
    chk($sformatf("vec%0d_write_cycles", idx), nw, v.we ? 1 : 0);
    chk($sformatf("vec%0d_read_cycles", idx), nr, v.we ? 0 : 1);
    chk($sformatf("vec%0d_other_done", idx), other, 1'b0);
    chk($sformatf("vec%0d_rdata", idx), rdata1, v.exp_rdata);
    chk($sformatf("vec%0d_owner", idx), owner1, v.port);
    @(negedge clk);
    chk($sformatf("vec%0d_busy_after", idx), busy1, 1'b0);
  endtask

  // Random-phase requester state and transaction-level reference model
  logic        req_v [2];
  logic        we_v [2];
  logic [31:0] addr_v [2];
  logic [31:0] wdata_v [2];
  bit          pend [2];
  logic [31:0] mdl [0:15];
  bit          active, exp_port, exp_we_t, lg, exp_owner, win, e_cd, e_dd, e_busy;
  int          grant_cyc, done_cyc, free_cyc;
  logic [31:0] exp_rdata, exp_rd_val;
  int          got [4];
  int          dcyc [4];
  int          ndone, cyc, nr3;
  bit          seen, addr_ok;
  logic [3:0]  mrpat;

  task automatic new_req(input int p);
    req_v[p]   = 1'b1;
    we_v[p]    = 1'($urandom_range(1, 0));
    addr_v[p]  = 32'($urandom_range(15, 0));
    wdata_v[p] = $urandom;
    pend[p]    = 1'b1;
  endtask

  task automatic drive_reqs();
    c1_req = req_v[0]; c1_we = we_v[0]; c1_addr = addr_v[0]; c1_wdata = wdata_v[0];
    d1_req = req_v[1]; d1_we = we_v[1]; d1_addr = addr_v[1]; d1_wdata = wdata_v[1];
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{1'b0, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF};
    vecs[1] = '{1'b1, 1'b1, 32'h20, 32'h12345678, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 1'b0, 32'h20, 32'h0,        32'h12345678};
    vecs[3] = '{1'b0, 1'b1, 32'h30, 32'hA5A5A5A5, 32'h12345678};
    vecs[4] = '{1'b0, 1'b0, 32'h30, 32'h0,        32'hA5A5A5A5};
    vecs[5] = '{1'b1, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF};

    rst = 1'b1;
    c1_req = 1'b0; c1_we = 1'b0; c1_addr = 32'h0; c1_wdata = 32'h0;
    d1_req = 1'b0; d1_we = 1'b0; d1_addr = 32'h0; d1_wdata = 32'h0;
    c3_req = 1'b0; c3_we = 1'b0; c3_addr = 32'h0; c3_wdata = 32'h0;
    d3_req = 1'b0; d3_we = 1'b0; d3_addr = 32'h0; d3_wdata = 32'h0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_core_done", c1_done, 1'b0);
    chk("rst_dbg_done", d1_done, 1'b0);
    chk("rst_busy", busy1, 1'b0);
    chk("rst_owner", owner1, 1'b0);
    chk("rst_rdata", rdata1, 32'h0);
    chk("rst_mem_address", ma1, 32'h0);
    chk("rst_mem_wdata", mwd1, 32'h0);
    chk("rst_mem_read", mr1, 1'b0);
    chk("rst_mem_write", mw1, 1'b0);
    chk("rst_busy3", busy3, 1'b0);
    rst = 1'b0;

    preload(1'b0, 8'h10, 32'hDEADBEEF);
    preload(1'b0, 8'h40, 32'h11111111);
    preload(1'b1, 8'h44, 32'hCAFEF00D);
    preload(1'b1, 8'h88, 32'h0BADBEEF);

    // Single core read, MEM_LAT=1, cycle by cycle
    c1_req = 1'b1; c1_we = 1'b0; c1_addr = 32'h10;
    @(negedge clk);
    chk("tp1_c1_mem_read", mr1, 1'b1);
    chk("tp1_c1_mem_address", ma1, 32'h10);
    chk("tp1_c1_busy", busy1, 1'b1);
    chk("tp1_c1_done", c1_done, 1'b0);
    @(negedge clk);
    chk("tp1_c2_done", c1_done, 1'b1);
    chk("tp1_c2_rdata", rdata1, 32'hDEADBEEF);
    chk("tp1_c2_mem_read", mr1, 1'b0);
    c1_req = 1'b0;
    @(negedge clk);
    chk("tp1_c3_busy", busy1, 1'b0);
    chk("tp1_c3_done", c1_done, 1'b0);

    // Table of single transactions on both ports
    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);
    chk("mem1_0x20", mem1[8'h20], 32'h12345678);

    // MEM_LAT=3 core read with the address changed mid-access
    c3_req = 1'b1; c3_we = 1'b0; c3_addr = 32'h44;
    cyc = 0; nr3 = 0; seen = 1'b0; addr_ok = 1'b1; mrpat = 4'b0000;
    while (!seen && cyc < 20) begin
      @(negedge clk); cyc++;
      if (cyc == 1) c3_addr = 32'h88;
      if (mr3) nr3++;
      if (cyc <= 4) mrpat[cyc-1] = mr3;
      if (busy3 && ma3 !== 32'h44) addr_ok = 1'b0;
      if (c3_done) seen = 1'b1;
    end
    c3_req = 1'b0;
    chk("lat3_done", seen, 1'b1);
    chk("lat3_latency", cyc, 4);
    chk("lat3_read_cycles", nr3, 3);
    chk("lat3_read_pattern", mrpat, 4'b0111);
    chk("lat3_addr_stable", addr_ok, 1'b1);
    chk("lat3_rdata", rdata3, 32'hCAFEF00D);
    @(negedge clk);
    chk("lat3_busy_after", busy3, 1'b0);

    // Both requests held from reset: grant order
    rst = 1'b1;
    c1_req = 1'b1; c1_we = 1'b0; c1_addr = 32'h10;
    d1_req = 1'b1; d1_we = 1'b0; d1_addr = 32'h20;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ndone = 0; cyc = 0;
    while (ndone < 4 && cyc < 40) begin
      @(negedge clk); cyc++;
      if (c1_done || d1_done) begin
        got[ndone] = d1_done ? 1 : 0;
        dcyc[ndone] = cyc;
        ndone++;
      end
    end
    c1_req = 1'b0; d1_req = 1'b0;
    chk("both_ndone", ndone, 4);
    chk("both_first_done_cycle", dcyc[0], 2);
    for (int i = 0; i < 4; i++) begin
`ifdef ARB_FIXED_PRIO_EN
      chk($sformatf("both_grant%0d", i), got[i], 0);
`else
      chk($sformatf("both_grant%0d", i), got[i], i % 2);
`endif
      if (i > 0) chk($sformatf("both_period%0d", i), dcyc[i] - dcyc[i-1], 3);
    end
    cyc = 0;
    while (busy1 && cyc < 10) begin @(negedge clk); cyc++; end
    chk("both_drain", busy1, 1'b0);

    // Reset during the first access cycle of a core write
    @(negedge clk);
    c1_req = 1'b1; c1_we = 1'b1; c1_addr = 32'h40; c1_wdata = 32'h99999999;
    @(posedge clk); #1;
    rst = 1'b1; c1_req = 1'b0;
    @(negedge clk);
    chk("rstw_mem_write", mw1, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    chk("rstw_busy", busy1, 1'b0);
    chk("rstw_owner", owner1, 1'b0);
    chk("rstw_rdata", rdata1, 32'h0);
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (c1_done || busy1) seen = 1'b1;
    end
    chk("rstw_no_done", seen, 1'b0);
    chk("rstw_mem_unchanged", mem1[8'h40], 32'h11111111);

    // Randomized traffic against the transaction-level model
    for (int i = 0; i < 16; i++) begin
      preload(1'b0, 8'(i), 32'hA0000000 + 32'(i));
      mdl[i] = 32'hA0000000 + 32'(i);
    end
    rst = 1'b1;
    for (int p = 0; p < 2; p++) begin
      req_v[p] = 1'b0; we_v[p] = 1'b0; addr_v[p] = 32'h0; wdata_v[p] = 32'h0; pend[p] = 1'b0;
    end
    drive_reqs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    active = 1'b0; lg = 1'b1; exp_owner = 1'b0; exp_rdata = 32'h0;
    free_cyc = 0; grant_cyc = 0; done_cyc = 0; exp_port = 1'b0; exp_we_t = 1'b0;
    for (int c = 0; c < 2500; c++) begin
      @(negedge clk);
      if (active && c == done_cyc && !exp_we_t) exp_rdata = exp_rd_val;
      e_busy = active && (c > grant_cyc);
      e_cd   = active && (c == done_cyc) && !exp_port;
      e_dd   = active && (c == done_cyc) && exp_port;
      chk("rnd_core_done", c1_done, e_cd);
      chk("rnd_dbg_done", d1_done, e_dd);
      chk("rnd_busy", busy1, e_busy);
      chk("rnd_rdata", rdata1, exp_rdata);
      chk("rnd_owner", owner1, exp_owner);
      for (int p = 0; p < 2; p++) begin
        if ((p == 0 && e_cd) || (p == 1 && e_dd)) begin
          pend[p] = 1'b0;
          if ($urandom_range(1, 0) == 1) new_req(p);
          else req_v[p] = 1'b0;
        end else if (!pend[p]) begin
          if ($urandom_range(3, 0) == 0) new_req(p);
        end else if (active && exp_port == p[0] && c < done_cyc && $urandom_range(7, 0) == 0) begin
          req_v[p] = 1'b0;
        end
      end
      drive_reqs();
      if (active && c == done_cyc) active = 1'b0;
      if (!active && c >= free_cyc && (req_v[0] || req_v[1])) begin
        if (req_v[0] && req_v[1]) begin
`ifdef ARB_FIXED_PRIO_EN
          win = 1'b0;
`else
          win = ~lg;
`endif
        end else begin
          win = req_v[1];
        end
        lg = win; exp_owner = win; exp_port = win; active = 1'b1;
        grant_cyc = c; done_cyc = c + 2; free_cyc = c + 3;
        exp_we_t = we_v[win];
        if (we_v[win]) mdl[addr_v[win][3:0]] = wdata_v[win];
        else exp_rd_val = mdl[addr_v[win][3:0]];
      end
    end
    for (int p = 0; p < 2; p++) req_v[p] = 1'b0;
    drive_reqs();
    cyc = 0;
    while (cyc < 5) begin @(negedge clk); cyc++; end
    chk("rnd_drain", busy1, 1'b0);
    for (int i = 0; i < 16; i++) chk($sformatf("rnd_mem%0d", i), mem1[i], mdl[i]);

    chk("unused_dbg_port", d3_served, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
